// File: rtl/dmem_responder_if.sv
// Memory-side handshake for the M stage: request fields from the pipeline,
// and completion, data and stall back from the responder.
interface dmem_responder_if #(
    parameter int WIDTH = 32
);
    logic             MemReqM;
    logic             MemWriteM;
    logic [WIDTH-1:0] ALUOutM;
    logic [WIDTH-1:0] WriteDataM;
    logic [3:0]       ByteEnM;
    logic [WIDTH-1:0] ReadDataM;
    logic             ReadyM;
    logic             ErrM;
    logic             StallM;

    modport master (
        output MemReqM, MemWriteM, ALUOutM, WriteDataM, ByteEnM,
        input  ReadDataM, ReadyM, ErrM, StallM
    );

    modport slave (
        input  MemReqM, MemWriteM, ALUOutM, WriteDataM, ByteEnM,
        output ReadDataM, ReadyM, ErrM, StallM
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed latency, stall and error reporting.
// Define DMEM_BYTE_LANES_EN to honour ByteEnM on stores; otherwise stores write full words.
//
// state | meaning
// IDLE  | waiting for MemReqM; accepts in the same cycle it is seen
// BUSY  | latency countdown, inputs ignored
// DONE  | one-cycle ReadyM pulse; store/load already applied on entry
module dmem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input logic            clk,
    input logic            reset,
    dmem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
    logic             we_q, err_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             accept, enter_done;
    logic [WIDTH-1:0] src_addr, src_wdata;
    logic             src_we, src_err;
    logic [AW-1:0]    src_idx;

`ifdef DMEM_BYTE_LANES_EN
    localparam int NLANE = (WIDTH / 8 < 4) ? WIDTH / 8 : 4;
    logic [3:0] be_q, src_be;
`else
    logic unused_be;
    assign unused_be = ^bus.ByteEnM;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MemReqM) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY);
                    state_d = (LATENCY > 0) ? BUSY : DONE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With zero latency the commit edge is also the accept edge, so the
    // request fields come straight from the bus rather than the latches.
    always_comb begin
        src_addr  = accept ? bus.ALUOutM    : addr_q;
        src_wdata = accept ? bus.WriteDataM : wdata_q;
        src_we    = accept ? bus.MemWriteM  : we_q;
`ifdef DMEM_BYTE_LANES_EN
        src_be    = accept ? bus.ByteEnM    : be_q;
`endif
    end

    assign enter_done = (state_d == DONE);
    assign src_idx    = src_addr[AW+1:2];
    assign src_err    = (src_addr[1:0] != 2'b00) | (|src_addr[WIDTH-1:AW+2]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef DMEM_BYTE_LANES_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.ALUOutM;
                wdata_q <= bus.WriteDataM;
                we_q    <= bus.MemWriteM;
`ifdef DMEM_BYTE_LANES_EN
                be_q    <= bus.ByteEnM;
`endif
            end
            if (enter_done) begin
                err_q <= src_err;
                if (!src_we) begin
                    rdata_q <= src_err ? '0 : mem[src_idx];
                end
            end
        end
    end

    // Array is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_done && src_we && !src_err) begin
`ifdef DMEM_BYTE_LANES_EN
            for (int i = 0; i < NLANE; i++) begin
                if (src_be[i]) begin
                    mem[src_idx][8*i +: 8] <= src_wdata[8*i +: 8];
                end
            end
`else
            mem[src_idx] <= src_wdata;
`endif
        end
    end

    assign bus.ReadDataM = rdata_q;
    assign bus.ReadyM    = (state_q == DONE);
    assign bus.ErrM      = (state_q == DONE) & err_q;
    assign bus.StallM    = ((state_q == IDLE) & bus.MemReqM) | (state_q == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_dmem_responder;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chkd;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

`ifdef DMEM_BYTE_LANES_EN
    localparam logic [31:0] V1 = 32'hDEADBEAA;
    localparam logic [31:0] V2 = 32'hDEADBEAA;
`else
    localparam logic [31:0] V1 = 32'h000000AA;
    localparam logic [31:0] V2 = 32'hFFFFFFFF;
`endif

    dmem_responder_if #(.WIDTH(32)) bus2 ();
    dmem_responder_if #(.WIDTH(32)) bus0 ();

    dmem_responder #(.WIDTH(32), .DEPTH(64), .LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    dmem_responder #(.WIDTH(32), .DEPTH(64), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_check(input string tag, inout exp_t q[$], input logic [31:0] rd,
                             input logic er);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_ready: got ReadyM at cycle %0d expected none", tag, cyc);
        end else begin
            e = q.pop_front();
            chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            chk({e.name, "_err"}, {31'd0, er}, {31'd0, e.err});
            if (e.chkd) chk({e.name, "_data"}, rd, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && bus2.ReadyM === 1'b1)
            pop_check("dut2", q2, bus2.ReadDataM, bus2.ErrM);
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && bus0.ReadyM === 1'b1)
            pop_check("dut0", q0, bus0.ReadDataM, bus0.ErrM);
    end

    // One request on the LATENCY=2 instance; inputs are scrambled during BUSY.
    task automatic req2(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic [31:0] exp_d, input logic exp_e,
                        input logic chkd, input string nm);
        int   st;
        exp_t e;
        st = 0;
        @(posedge clk); #1;
        bus2.MemReqM    = 1'b1;
        bus2.MemWriteM  = we;
        bus2.ALUOutM    = addr;
        bus2.WriteDataM = data;
        bus2.ByteEnM    = be;
        e.data = exp_d; e.err = exp_e; e.chkd = chkd; e.cyc = cyc + 3; e.name = nm;
        q2.push_back(e);
        @(negedge clk); st += int'(bus2.StallM);
        @(posedge clk); #1;
        bus2.MemReqM    = 1'b0;
        bus2.MemWriteM  = ~we;
        bus2.ALUOutM    = 32'h4;
        bus2.WriteDataM = 32'h0BAD0BAD;
        repeat (3) begin
            @(negedge clk); st += int'(bus2.StallM);
        end
        chk({nm, "_stall_cycles"}, 32'(st), 32'd3);
    endtask

    task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_d, input logic chkd, input string nm);
        exp_t e;
        @(posedge clk); #1;
        bus0.MemReqM    = 1'b1;
        bus0.MemWriteM  = we;
        bus0.ALUOutM    = addr;
        bus0.WriteDataM = data;
        bus0.ByteEnM    = 4'hF;
        e.data = exp_d; e.err = 1'b0; e.chkd = chkd; e.cyc = cyc + 1; e.name = nm;
        q0.push_back(e);
        @(posedge clk); #1;
        bus0.MemReqM = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus2.MemReqM = 1'b0; bus2.MemWriteM = 1'b0; bus2.ALUOutM = '0;
        bus2.WriteDataM = '0; bus2.ByteEnM = '0;
        bus0.MemReqM = 1'b0; bus0.MemWriteM = 1'b0; bus0.ALUOutM = '0;
        bus0.WriteDataM = '0; bus0.ByteEnM = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        repeat (5) begin
            @(negedge clk);
            chk("idle_rdata", bus2.ReadDataM, 32'h0);
            chk("idle_ctrl", {29'd0, bus2.ReadyM, bus2.ErrM, bus2.StallM}, 32'h0);
        end

        req2(1'b1, 32'h00, 32'h55AA55AA, 4'hF, 32'h0, 1'b0, 1'b0, "st0");
        req2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, "st10");
        req2(1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 1'b1, "ld10");
        req2(1'b1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 1'b0, 1'b0, "st10_lane0");
        req2(1'b0, 32'h10, 32'h0,        4'hF, V1, 1'b0, 1'b1, "ld10_lane0");
        req2(1'b0, 32'h12, 32'h0,        4'hF, 32'h0, 1'b1, 1'b1, "ld_misaligned");
        req2(1'b1, 32'h100, 32'h12345678, 4'hF, 32'h0, 1'b1, 1'b0, "st_out_of_range");
        chk("rdata_after_oor_store", bus2.ReadDataM, 32'h0);
        req2(1'b0, 32'h00, 32'h0,        4'hF, 32'h55AA55AA, 1'b0, 1'b1, "ld0_unchanged");
        req2(1'b1, 32'hFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0, "st_top");
        req2(1'b0, 32'hFC, 32'h0,        4'hF, 32'hCAFEF00D, 1'b0, 1'b1, "ld_top");
        req2(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1'b0, "st_be_zero");
        req2(1'b0, 32'h10, 32'h0,        4'h0, V2, 1'b0, 1'b1, "ld_be_zero");

        req0(1'b1, 32'h08, 32'h11111111, 32'h0, 1'b0, "z_st8");
        req0(1'b1, 32'h0C, 32'h22222222, 32'h0, 1'b0, "z_stC");
        @(posedge clk); #1;
        bus0.MemReqM = 1'b1; bus0.MemWriteM = 1'b0; bus0.ALUOutM = 32'h08;
        e.data = 32'h11111111; e.err = 1'b0; e.chkd = 1'b1; e.cyc = cyc + 1; e.name = "z_b2b_ld8";
        q0.push_back(e);
        e.data = 32'h22222222; e.cyc = cyc + 3; e.name = "z_b2b_ldC";
        q0.push_back(e);
        @(negedge clk); chk("z_stall_accept1", {31'd0, bus0.StallM}, 32'd1);
        @(posedge clk); #1;
        bus0.ALUOutM = 32'h0C;
        @(negedge clk); chk("z_stall_done1", {31'd0, bus0.StallM}, 32'd0);
        @(negedge clk); chk("z_stall_accept2", {31'd0, bus0.StallM}, 32'd1);
        @(posedge clk); #1;
        bus0.MemReqM = 1'b0;
        @(negedge clk); chk("z_stall_done2", {31'd0, bus0.StallM}, 32'd0);

        @(posedge clk); #1;
        bus2.MemReqM = 1'b1; bus2.MemWriteM = 1'b1; bus2.ALUOutM = 32'h10;
        bus2.WriteDataM = 32'h99999999; bus2.ByteEnM = 4'hF;
        @(posedge clk); #1;
        bus2.MemReqM = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_rdata", bus2.ReadDataM, 32'h0);
        chk("rst_mid_ctrl", {29'd0, bus2.ReadyM, bus2.ErrM, bus2.StallM}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req2(1'b0, 32'h10, 32'h0, 4'hF, V2, 1'b0, 1'b1, "ld_after_reset");

        repeat (4) @(negedge clk);
        chk("dut2_queue_drained", 32'(q2.size()), 32'd0);
        chk("dut0_queue_drained", 32'(q0.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
